// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO.
//   ptr_width : pointer width for a given depth (address bits plus one wrap bit)
//   is_pow2   : depth legality (power of two, at least 2)
//   af_legal  : almost-full threshold within 1..depth
//   ae_legal  : almost-empty threshold within 0..depth-1
package sync_fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit af_legal(input int unsigned af, input int unsigned depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_legal(input int unsigned ae, input int unsigned depth);
    return ae <= (depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_param: DATA_DEPTH x DATA_WIDTH, one synchronous
// write port and one asynchronous read port. Contents are not reset.
//   clk      in  clock, rising edge
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address
//   rd_data  out read data (combinational from rd_addr)
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned AW         = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/almost-empty
// flags, standard or first-word-fall-through read mode, synchronous flush and
// one-cycle overflow/underflow pulses.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear, overrides wr_en/rd_en
//   wr_en/data_in  write request and data
//   rd_en          read request (FWFT: pop of the head word)
//   data_out       read data; rd_valid marks a fresh word (standard) or !empty (FWFT)
//   full/empty/almost_full/almost_empty/count  status from registered pointers
//   overflow/underflow  registered pulses for rejected write/read requests
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DATA_DEPTH):0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = ptr_width(DATA_DEPTH);
  localparam int unsigned AW = PW - 1;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);

  if (!is_pow2(DATA_DEPTH)) begin : g_chk_depth
    $error("sync_fifo_param: DATA_DEPTH must be a power of two >= 2");
  end
  if (!af_legal(AF_THRESH, DATA_DEPTH)) begin : g_chk_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DATA_DEPTH");
  end
  if (!ae_legal(AE_THRESH, DATA_DEPTH)) begin : g_chk_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DATA_DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Status is purely a function of the registered pointers.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count        = wr_ptr_q - rd_ptr_q;
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
  end

  // Full blocks only the write and empty blocks only the read, so a
  // simultaneous request on a full/empty FIFO still moves the other pointer.
  always_comb begin
    wr_acc      = wr_en & ~full & ~flush;
    rd_acc      = rd_en & ~empty & ~flush;
    overflow_d  = wr_en & full & ~flush;
    underflow_d = rd_en & empty & ~flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; forced to zero while empty so the output is
    // defined after reset even though the array is not.
    always_comb begin
      data_out = empty ? '0 : ram_rd_data;
      rd_valid = ~empty;
    end
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      dout_d     = rd_acc ? ram_rd_data : dout_q;
      rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
